mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 15, max cycles mem_en may wait for mem_ack.
REQ-002 SHALL provide ports, one per line: name  direction  width  meaning.
  clk  input  1  single clock, all logic on rising edge
  reset  input  1  synchronous, active-high reset
  req_valid  input  1  core access request, held until done
  req_write  input  1  1 = store, 0 = load
  req_addr  input  32  byte address
  req_wdata  input  32  store data, right-aligned
  req_size  input  3  MemSize code: 000 B, 001 H, 010 W, 100 BU, 101 HU; others unsupported
  done  output  1  one-cycle completion pulse
  err  output  1  valid with done; access failed
  err_code  output  2  00 none, 01 misaligned, 10 unsupported size, 11 timeout
  rdata  output  32  extended load data, valid with done
  mem_en  output  1  memory access strobe
  mem_we  output  1  memory write enable
  mem_be  output  4  byte lane enables
  mem_addr  output  32  word address, {req_addr[31:2],2'b00}
  mem_wdata  output  32  lane-replicated store data
  mem_rdata  input  32  memory read word
  mem_ack  input  1  memory completion, sampled when mem_en=1

Function
REQ-003 SHALL implement states IDLE, CHECK, ACCESS, RESP, FAIL.
REQ-004 IDLE: on req_valid=1 SHALL register write, addr, wdata, size and go to CHECK; only IDLE accepts requests.
REQ-005 CHECK: size code 011/110/111 -> FAIL, err_code 10; H/HU with addr[0]=1 or W with addr[1:0]!=0 -> FAIL, err_code 01; else ACCESS. Size check takes priority.
REQ-006 ACCESS: mem_en=1, mem_we=registered write, mem_be/mem_addr/mem_wdata stable the whole state; on mem_ack=1 -> RESP.
REQ-007 ACCESS: wait counter SHALL reset on entry, increment per cycle without ack; when it reaches TIMEOUT_CYCLES without ack -> FAIL, err_code 11, mem_en deasserted next cycle.
REQ-008 mem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-009 mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-010 On the ack cycle SHALL capture mem_rdata shifted right by 8*addr[1:0], then sign-extend (B,H) or zero-extend (BU,HU) to 32 bits; stores return rdata=0.
REQ-011 RESP: done=1, err=0, err_code=00 for exactly one cycle, then IDLE.
REQ-012 FAIL: done=1, err=1, err_code held, rdata=0, mem_en=0 for exactly one cycle, then IDLE; memory is never touched on misaligned/unsupported requests.
REQ-013 Latency: request seen in IDLE at cycle N, ack in first ACCESS cycle N+2 -> done at N+3; misaligned/unsupported -> done at N+2.
REQ-014 req_valid still high in the done cycle SHALL be ignored; the core drops it on done; a held request restarts only from IDLE.
REQ-015 mem_ack outside ACCESS SHALL be ignored.
REQ-016 done, err, err_code, rdata SHALL be registered; no combinational path req_* -> done.

Reset
REQ-017 On a rising edge with reset=1: state IDLE, counter 0, captured registers 0, all outputs 0 (mem_en, mem_we, mem_be, mem_addr, mem_wdata, done, err, err_code, rdata).
REQ-018 Reset mid-ACCESS SHALL abort the access with no done pulse; mem_en is 0 from the cycle after the reset edge.
REQ-019 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-020 Package mem_pkg SHALL hold the state enum, req_size encoding constants, and err_code constants; the control FSM imports the same size constants.
REQ-021 Combinational sub-module mem_lane_align SHALL hold be generation, store replication, and load extraction/extension; the FSM, counter, and registers stay in mem_access_ctrl.

Verification
REQ-022 LW addr 0x100, mem_rdata 0xDEADBEEF, ack first ACCESS cycle -> mem_be 1111, mem_addr 0x100, done 3 cycles after request, rdata 0xDEADBEEF, err 0.
REQ-023 LB addr 0x103, mem_rdata 0x80FF0000 -> be 1000, rdata 0xFFFFFF80; same with LBU -> rdata 0x00000080.
REQ-024 SH addr 0x202, wdata 0x0000ABCD -> mem_we 1, be 1100, mem_wdata 0xABCDABCD, mem_addr 0x200; SW addr 0x201 -> no mem_en, done+err, err_code 01.
REQ-025 req_size 011 at addr 0x0 -> no mem_en, err_code 10; mem_ack held 0 with TIMEOUT_CYCLES=15 -> mem_en high 15 cycles, then done+err, err_code 11.
REQ-026 Reset asserted on third ACCESS cycle -> no done, mem_en 0 next cycle, all outputs 0; new LW after reset completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory access controller.
//   state_t        control FSM states
//   SZ_*           req_size (MemSize) encodings
//   ERR_*          err_code values
//   size_supported / size_misaligned  request legality helpers
package mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ACCESS,
        ST_RESP,
        ST_FAIL
    } state_t;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_SIZE     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    function automatic logic size_supported(input logic [2:0] sz);
        case (sz)
            SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: size_supported = 1'b1;
            default:                        size_supported = 1'b0;
        endcase
    endfunction

    function automatic logic size_misaligned(input logic [2:0] sz, input logic [1:0] off);
        case (sz)
            SZ_H, SZ_HU: size_misaligned = off[0];
            SZ_W:        size_misaligned = (off != 2'b00);
            default:     size_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core-request and memory-bus signals of the memory access controller.
//   req_*              core request (held until done)
//   done/err/err_code/rdata  completion response
//   mem_*              memory-side strobe, lanes, data and ack
// slave modport: controller side; master modport: core/memory side.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [31:0] rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size,
        input  mem_rdata, mem_ack,
        output done, err, err_code, rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size,
        output mem_rdata, mem_ack,
        input  done, err, err_code, rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic for sub-word accesses.
//   size_i       MemSize code of the access
//   off_i        byte offset within the word (addr[1:0])
//   wdata_i      right-aligned store data
//   mem_rdata_i  raw memory read word
//   be_o         byte lane enables
//   wdata_o      store data replicated across lanes
//   rdata_o      load data shifted down and sign/zero extended
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = mem_rdata_i >> {off_i, 3'b000};
        be_o    = '0;
        wdata_o = '0;
        rdata_o = '0;
        case (size_i)
            SZ_B: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_BU: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {24'd0, shifted[7:0]};
            end
            SZ_H: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            end
            SZ_HU: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {16'd0, shifted[15:0]};
            end
            SZ_W: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = shifted;
            end
            default: begin
                be_o    = '0;
                wdata_o = '0;
                rdata_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: accepts one core load/store at a time, checks
// size and alignment, drives a single memory access with a bounded wait for
// mem_ack, and returns a registered one-cycle done pulse with status/data.
//   clk, reset  single clock, synchronous active-high reset
//   bus         mem_access_ctrl_if.slave (request, response, memory bus)
// Parameter TIMEOUT_CYCLES: max cycles mem_en stays high waiting for mem_ack.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                reset,
    mem_access_ctrl_if.slave    bus
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q;
    logic               wr_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [2:0]         size_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               done_q;
    logic               err_q;
    logic [1:0]         code_q;
    logic [31:0]        rdata_q;
    logic               en_q;
    logic               we_q;
    logic [3:0]         be_q;
    logic [31:0]        maddr_q;
    logic [31:0]        mwdata_q;

    logic [3:0]         lane_be;
    logic [31:0]        lane_wdata;
    logic [31:0]        lane_rdata;

    mem_lane_align u_lane (
        .size_i      (size_q),
        .off_i       (addr_q[1:0]),
        .wdata_i     (wdata_q),
        .mem_rdata_i (bus.mem_rdata),
        .be_o        (lane_be),
        .wdata_o     (lane_wdata),
        .rdata_o     (lane_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            cnt_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            code_q   <= ERR_NONE;
            rdata_q  <= '0;
            en_q     <= '0;
            we_q     <= '0;
            be_q     <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            // Response outputs are pulses: they are only set on the edge
            // entering RESP/FAIL and fall back to zero on the following edge.
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            rdata_q <= '0;

            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        wr_q    <= bus.req_write;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        size_q  <= bus.req_size;
                        state_q <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (!size_supported(size_q)) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        code_q  <= ERR_SIZE;
                        state_q <= ST_FAIL;
                    end else if (size_misaligned(size_q, addr_q[1:0])) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        code_q  <= ERR_MISALIGN;
                        state_q <= ST_FAIL;
                    end else begin
                        // Memory-side outputs are loaded once here and held
                        // unchanged for the whole ACCESS state.
                        en_q     <= 1'b1;
                        we_q     <= wr_q;
                        be_q     <= lane_be;
                        maddr_q  <= {addr_q[31:2], 2'b00};
                        mwdata_q <= lane_wdata;
                        cnt_q    <= '0;
                        state_q  <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    if (bus.mem_ack) begin
                        en_q    <= 1'b0;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        rdata_q <= wr_q ? '0 : lane_rdata;
                        state_q <= ST_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        // Last allowed cycle without ack: mem_en has then been
                        // high for exactly TIMEOUT_CYCLES cycles.
                        en_q    <= 1'b0;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        code_q  <= ERR_TIMEOUT;
                        state_q <= ST_FAIL;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_RESP, ST_FAIL: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.err_code  = code_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_en    = en_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = mwdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, a reset
// abort sequence, and randomized transactions against a transaction-level
// reference model.
module tb_mem_access_ctrl;

    localparam int T = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          done_c;
        int          en_n;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  code;
    } obs_t;

    typedef struct {
        string       name;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          lat;
        int          done_c;
        int          en_n;
        logic [1:0]  code;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic [31:0] maddr;
        logic        we;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom();
    endtask

    // Transaction-level reference: outcome of one request given the cycle
    // (relative to the first ACCESS cycle) at which memory acks; lat<0 = never.
    task automatic model(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int lat,
                         output int code, output int done_off, output int en_n,
                         output logic [3:0] be, output logic [31:0] wdo,
                         output logic [31:0] rdo);
        int nb;
        bit sgn;
        int off;
        longint v;
        longint mask;
        nb = 0; sgn = 0;
        case (sz)
            3'b000: begin nb = 1; sgn = 1; end
            3'b001: begin nb = 2; sgn = 1; end
            3'b010: begin nb = 4; sgn = 0; end
            3'b100: begin nb = 1; sgn = 0; end
            3'b101: begin nb = 2; sgn = 0; end
            default: nb = 0;
        endcase
        off = int'(a % 4);
        be = '0; wdo = '0; rdo = '0;
        if (nb == 0) begin
            code = 2; done_off = 2; en_n = 0;
        end else if (off % nb != 0) begin
            code = 1; done_off = 2; en_n = 0;
        end else if (lat < 0 || lat >= T) begin
            code = 3; done_off = 2 + T; en_n = T;
        end else begin
            code = 0; done_off = 3 + lat; en_n = lat + 1;
        end
        if (nb != 0) begin
            be = 4'(((1 << nb) - 1) << off);
            for (int i = 0; i < 4; i++)
                wdo[8*i +: 8] = wd[8*(i % nb) +: 8];
            if (code == 0 && !wr) begin
                mask = (longint'(1) << (8 * nb)) - 1;
                v = (longint'(rd) >> (8 * off)) & mask;
                if (sgn && v >= (longint'(1) << (8 * nb - 1)))
                    v = v - (longint'(1) << (8 * nb));
                rdo = v[31:0];
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            bus.req_valid = 1'b0;
            noise();
            chk("idle.mem_en", 32'(bus.mem_en), 32'd0);
            chk("idle.done", 32'(bus.done), 32'd0);
        end
    endtask

    // Issue one request in the next cycle and follow it to its done cycle,
    // checking every cycle against the model. req_valid stays high through
    // the done cycle, which the controller must ignore.
    task automatic run_txn(input string tag, input logic wr, input logic [2:0] sz,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int lat, output obs_t o);
        int code, done_off, en_n;
        logic [3:0] be;
        logic [31:0] wdo, rdo;
        bit in_win;
        model(wr, sz, a, wd, rd, lat, code, done_off, en_n, be, wdo, rdo);
        o = '{done_c: -1, en_n: 0, we: 0, be: 0, addr: 0, wdata: 0, rdata: 0, err: 0, code: 0};
        for (int c = 0; c <= done_off; c++) begin
            step();
            if (c == 0) begin
                bus.req_valid = 1'b1;
                bus.req_write = wr;
                bus.req_addr  = a;
                bus.req_wdata = wd;
                bus.req_size  = sz;
            end
            in_win = (c >= 2) && (c < 2 + en_n);
            if (in_win) begin
                bus.mem_ack   = (code == 0) && (c == 2 + lat);
                bus.mem_rdata = bus.mem_ack ? rd : $urandom();
            end else begin
                noise();
            end
            chk({tag, ".mem_en"}, 32'(bus.mem_en), 32'(in_win));
            if (bus.mem_en) begin
                o.en_n++;
                if (o.en_n == 1) begin
                    o.we = bus.mem_we; o.be = bus.mem_be;
                    o.addr = bus.mem_addr; o.wdata = bus.mem_wdata;
                end
            end
            if (in_win) begin
                chk({tag, ".mem_we"}, 32'(bus.mem_we), 32'(wr));
                chk({tag, ".mem_be"}, 32'(bus.mem_be), 32'(be));
                chk({tag, ".mem_addr"}, bus.mem_addr, a & ~32'h3);
                chk({tag, ".mem_wdata"}, bus.mem_wdata, wdo);
            end
            chk({tag, ".done"}, 32'(bus.done), 32'(c == done_off));
            if (bus.done && o.done_c < 0) begin
                o.done_c = c; o.err = bus.err; o.code = bus.err_code; o.rdata = bus.rdata;
            end
            if (c == done_off) begin
                chk({tag, ".err"}, 32'(bus.err), 32'(code != 0));
                chk({tag, ".err_code"}, 32'(bus.err_code), 32'(code));
                chk({tag, ".rdata"}, bus.rdata, rdo);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_en"}, 32'(bus.mem_en), 32'd0);
        chk({tag, ".mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, ".mem_be"}, 32'(bus.mem_be), 32'd0);
        chk({tag, ".mem_addr"}, bus.mem_addr, 32'd0);
        chk({tag, ".mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, ".done"}, 32'(bus.done), 32'd0);
        chk({tag, ".err"}, 32'(bus.err), 32'd0);
        chk({tag, ".err_code"}, 32'(bus.err_code), 32'd0);
        chk({tag, ".rdata"}, bus.rdata, 32'd0);
    endtask

    vec_t tbl[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        tbl[0]  = '{"lw_100",      0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0,  3,  1, 2'd0, 32'hDEADBEEF, 4'hF, 32'h0,        32'h100, 0};
        tbl[1]  = '{"lb_103",      0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 0,  3,  1, 2'd0, 32'hFFFFFF80, 4'h8, 32'h0,        32'h100, 0};
        tbl[2]  = '{"lbu_103",     0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 0,  3,  1, 2'd0, 32'h00000080, 4'h8, 32'h0,        32'h100, 0};
        tbl[3]  = '{"sh_202",      1, 3'b001, 32'h202, 32'h0000ABCD, 32'h11111111, 0,  3,  1, 2'd0, 32'h0,        4'hC, 32'hABCDABCD, 32'h200, 1};
        tbl[4]  = '{"sw_201",      1, 3'b010, 32'h201, 32'h12345678, 32'h0,        0,  2,  0, 2'd1, 32'h0,        4'h0, 32'h0,        32'h0,   0};
        tbl[5]  = '{"sz011_0",     0, 3'b011, 32'h0,   32'h0,        32'h0,        0,  2,  0, 2'd2, 32'h0,        4'h0, 32'h0,        32'h0,   0};
        tbl[6]  = '{"lw_timeout",  0, 3'b010, 32'h400, 32'h0,        32'h0,        -1, 17, 15, 2'd3, 32'h0,       4'hF, 32'h0,        32'h400, 0};
        tbl[7]  = '{"lh_102_lat2", 0, 3'b001, 32'h102, 32'h0,        32'h80010000, 2,  5,  3, 2'd0, 32'hFFFF8001, 4'hC, 32'h0,        32'h100, 0};
        tbl[8]  = '{"lhu_101",     0, 3'b101, 32'h101, 32'h0,        32'h0,        0,  2,  0, 2'd1, 32'h0,        4'h0, 32'h0,        32'h0,   0};
        tbl[9]  = '{"sb_101",      1, 3'b000, 32'h101, 32'h12345678, 32'h0,        1,  4,  2, 2'd0, 32'h0,        4'h2, 32'h78787878, 32'h100, 1};
        tbl[10] = '{"sz111_003",   0, 3'b111, 32'h3,   32'h0,        32'h0,        0,  2,  0, 2'd2, 32'h0,        4'h0, 32'h0,        32'h0,   0};
        tbl[11] = '{"lw_ack_last", 0, 3'b010, 32'h50C, 32'h0,        32'hCAFEF00D, 14, 17, 15, 2'd0, 32'hCAFEF00D, 4'hF, 32'h0,       32'h50C, 0};
        tbl[12] = '{"lhu_102",     0, 3'b101, 32'h102, 32'h0,        32'h80010000, 0,  3,  1, 2'd0, 32'h00008001, 4'hC, 32'h0,        32'h100, 0};

        // Reset with a request and ack present: reset must win.
        reset = 1'b1;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h100;
        bus.req_wdata = 32'h0; bus.req_size = 3'b010;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
        repeat (3) step();
        chk_all_zero("reset");
        reset = 1'b0;
        bus.req_valid = 1'b0;
        idle(2);

        foreach (tbl[i]) begin
            run_txn(tbl[i].name, tbl[i].wr, tbl[i].sz, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].lat, o);
            chk({tbl[i].name, ".v_done_cycle"}, 32'(o.done_c), 32'(tbl[i].done_c));
            chk({tbl[i].name, ".v_en_cycles"}, 32'(o.en_n), 32'(tbl[i].en_n));
            chk({tbl[i].name, ".v_err"}, 32'(o.err), 32'(tbl[i].code != 0));
            chk({tbl[i].name, ".v_err_code"}, 32'(o.code), 32'(tbl[i].code));
            chk({tbl[i].name, ".v_rdata"}, o.rdata, tbl[i].rdata);
            if (tbl[i].en_n > 0) begin
                chk({tbl[i].name, ".v_be"}, 32'(o.be), 32'(tbl[i].be));
                chk({tbl[i].name, ".v_wdata"}, o.wdata, tbl[i].mwd);
                chk({tbl[i].name, ".v_addr"}, o.addr, tbl[i].maddr);
                chk({tbl[i].name, ".v_we"}, 32'(o.we), 32'(tbl[i].we));
            end
            idle(i % 2);
        end

        // Reset on the third ACCESS cycle aborts without a done pulse.
        idle(1);
        step();
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h300;
        bus.req_wdata = 32'h0; bus.req_size = 3'b010;
        noise();
        step();
        noise();
        for (int c = 2; c <= 4; c++) begin
            step();
            bus.mem_ack = 1'b0;
            bus.mem_rdata = $urandom();
            chk("rst_abort.mem_en", 32'(bus.mem_en), 32'd1);
            chk("rst_abort.done", 32'(bus.done), 32'd0);
            if (c == 4) reset = 1'b1;
        end
        step();
        chk_all_zero("rst_abort.after");
        reset = 1'b0;
        bus.req_valid = 1'b0;
        idle(4);
        run_txn("lw_after_reset", 1'b0, 3'b010, 32'h104, 32'h0, 32'h13572468, 1, o);
        chk("lw_after_reset.v_done_cycle", 32'(o.done_c), 32'd4);
        chk("lw_after_reset.v_rdata", o.rdata, 32'h13572468);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            logic [2:0] sz;
            int r, lat;
            r = int'($urandom_range(0, 19));
            if (r < 2) begin
                case ($urandom_range(0, 2))
                    0: sz = 3'b011;
                    1: sz = 3'b110;
                    default: sz = 3'b111;
                endcase
            end else begin
                case ($urandom_range(0, 4))
                    0: sz = 3'b000;
                    1: sz = 3'b001;
                    2: sz = 3'b010;
                    3: sz = 3'b100;
                    default: sz = 3'b101;
                endcase
            end
            lat = ($urandom_range(0, 29) == 0) ? -1 : int'($urandom_range(0, 5));
            run_txn("rand", 1'($urandom_range(0, 1)), sz, $urandom(), $urandom(), $urandom(), lat, o);
            idle(int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
